food_spawn_ctrl: RTL and testbench
==================================

# food_spawn_ctrl

Controller that sequences food placement for the snake game. On request it steps the external LFSR pair and latches a candidate 3x3 food anchor. It rejects candidates that fall outside the playfield or overlap the snake (via a one-cycle-latency occupancy query port), then writes the nine food pixels into the frame buffer through a ready/we handshake. It sits between the game FSM, the LFSR datapath, the snake-body occupancy memory and the VGA frame-buffer writer, and it produces the `write_done` pulse consumed by the food datapath.

## Interface
- `X_MAX`, default 640: playfield width in pixels.
- `Y_MAX`, default 480: playfield height in pixels.
- `MAX_TRIES`, default 15: maximum rejected candidates before giving up; legal range 1..255.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `spawn_req`  in  1  start a spawn; sampled only in IDLE.
- `rnd_x`  in  10  LFSR x output.
- `rnd_y`  in  10  LFSR y output; only bits [8:0] are used.
- `lfsr_step`  out  1  one-cycle pulse that advances both LFSRs.
- `occ_x`  out  10  occupancy query x.
- `occ_y`  out  9  occupancy query y.
- `occ_hit`  in  1  occupancy result for the query issued in the previous cycle.
- `pix_x`  out  10  frame-buffer write x.
- `pix_y`  out  9  frame-buffer write y.
- `pix_we`  out  1  write request; held until accepted.
- `pix_ready`  in  1  write accepted in any cycle where `pix_we` && `pix_ready`.
- `food_x`  out  10  anchor x of the current food.
- `food_y`  out  9  anchor y of the current food.
- `food_valid`  out  1  food is placed and drawn.
- `write_done`  out  1  one-cycle pulse when drawing completes.
- `busy`  out  1  high in every state except IDLE.
- `fail`  out  1  one-cycle pulse when MAX_TRIES is exhausted.

## Operation
- Cell order is k = 0..8, with dx = k%3 and dy = k/3. Each cell is (cx+dx, cy+dy).
- **IDLE**
  - If `spawn_req` is high: clear `food_valid`, clear `try_cnt`, go to STEP.
- **STEP**
  - Drive `lfsr_step` = 1 for this cycle only, then go to LATCH.
- **LATCH**
  - Set cx = `rnd_x` and cy = `rnd_y[8:0]`.
  - If cx > X_MAX-3 or cy > Y_MAX-3, the candidate is rejected.
  - Otherwise go to CHECK with k = 0.
- **CHECK**
  - Issue the query for cell k on `occ_x`/`occ_y` each cycle, for k = 0..8.
  - Sample `occ_hit` one cycle later. This takes 10 cycles total; the last cycle issues nothing and only samples.
  - On the first `occ_hit`=1, the candidate is rejected immediately. No further queries are issued.
  - If all nine samples are 0, go to DRAW with k = 0.
- **Reject path**
  - Increment `try_cnt`.
  - If `try_cnt` then equals MAX_TRIES, go to FAIL; otherwise go to STEP.
- **DRAW**
  - Hold `pix_we`=1 with cell k on `pix_x`/`pix_y` until `pix_ready`=1, then advance k.
  - After k = 8 is accepted, go to DONE.
- **DONE**
  - Pulse `write_done`=1.
  - Load `food_x`=cx and `food_y`=cy.
  - Set `food_valid`=1, go to IDLE.
- **FAIL**
  - Pulse `fail`=1. `food_valid` stays 0; `food_x`/`food_y` are unchanged. Go to IDLE.
- `spawn_req` outside IDLE is ignored and is not queued.
- All coordinate arithmetic is unsigned. cx+2 and cy+2 never overflow because of the bound check.

## Timing
- **Reset** (`reset`=0, asynchronous):
  - State goes to IDLE; `try_cnt` and k go to 0.
  - All outputs go to 0: `lfsr_step`, `occ_x`, `occ_y`, `pix_x`, `pix_y`, `pix_we`, `food_x`, `food_y`, `food_valid`, `write_done`, `busy`, `fail`.
- Reset during any state, including mid-DRAW, aborts immediately. No further pixels are written after release.
- Release from reset is synchronous to `clk`; first action is possible on the cycle after release.
- Best case, with `spawn_req` at cycle 0 and `pix_ready` tied to 1:
  - STEP at 1, LATCH at 2, CHECK at 3–12, DRAW at 13–21.
  - `write_done` at 22, `food_valid` high from 23.
- Each rejection in CHECK costs (cycles spent in CHECK) + 2 before the next LATCH.
- An out-of-bounds rejection in LATCH costs 2 cycles.
- `pix_ready` low stalls DRAW indefinitely. `pix_x`, `pix_y` and `pix_we` must be stable while stalled.
- `occ_x`/`occ_y` are registered outputs; `occ_hit` is registered inside the occupancy memory.

## Test plan
- **No obstruction:** `rnd_x`=100, `rnd_y`=50, `occ_hit`=0, `pix_ready`=1 → nine writes in order (100,50),(101,50),(102,50),(100,51)…(102,52), `write_done` at cycle 22, `food_x`=100, `food_y`=50, `food_valid`=1.
- **Out of bounds then valid:** first candidate `rnd_x`=638, second `rnd_x`=200, `rnd_y`=10 → `lfsr_step` pulses twice, no query is issued for 638, food lands at (200,10).
- **Occupancy hit:** `occ_hit`=1 for cell k=4 of the first candidate → queries stop after k=4, one extra `lfsr_step` pulse, second candidate drawn, `try_cnt`=1 before DONE.
- **Exhaustion:** MAX_TRIES=3 and every candidate hits at k=0 → exactly 3 `lfsr_step` pulses, `fail` pulse, `food_valid`=0, no `pix_we`.
- **Backpressure:** `pix_ready` low for 5 cycles at k=2 → `pix_x`/`pix_y`/`pix_we` held stable, exactly nine accepted writes, `write_done` 5 cycles later than the no-stall case.
- **Reset and ignored request:** drive `reset` low during DRAW at k=5 → all outputs 0 immediately. Assert `spawn_req` while `busy` in a fresh run → no second spawn and no extra `lfsr_step`.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: draws LFSR candidates, rejects out-of-bounds or occupied
// 3x3 anchors, then writes the nine food pixels through a ready/we handshake.
module food_spawn_ctrl #(
   parameter int unsigned X_MAX     = 640,
   parameter int unsigned Y_MAX     = 480,
   parameter int unsigned MAX_TRIES = 15
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_spawn_req,
   input  logic [9:0] i_rnd_x,
   input  logic [9:0] i_rnd_y,
   output logic       o_lfsr_step,
   output logic [9:0] o_occ_x,
   output logic [8:0] o_occ_y,
   input  logic       i_occ_hit,
   output logic [9:0] o_pix_x,
   output logic [8:0] o_pix_y,
   output logic       o_pix_we,
   input  logic       i_pix_ready,
   output logic [9:0] o_food_x,
   output logic [8:0] o_food_y,
   output logic       o_food_valid,
   output logic       o_write_done,
   output logic       o_busy,
   output logic       o_fail
);

   localparam logic [9:0] XLim   = 10'(X_MAX - 3);
   localparam logic [8:0] YLim   = 9'(Y_MAX - 3);
   localparam logic [7:0] TryMax = 8'(MAX_TRIES);

   typedef enum logic [2:0] {
      StIdle, StStep, StLatch, StCheck, StDraw, StDone, StFail
   } state_e;

   state_e     r_state;
   logic [9:0] r_cx;
   logic [8:0] r_cy;
   logic [3:0] r_k;
   logic [7:0] r_try_cnt;
   logic [9:0] r_occ_x;
   logic [8:0] r_occ_y;
   logic [9:0] r_pix_x;
   logic [8:0] r_pix_y;
   logic       r_pix_we;
   logic [9:0] r_food_x;
   logic [8:0] r_food_y;
   logic       r_food_valid;
   logic       r_lfsr_step;
   logic       r_write_done;
   logic       r_fail;

   logic       w_oob;
   logic       w_reject;
   logic [7:0] w_try_next;
   logic [3:0] w_k_next;
   logic [9:0] w_cell_x;
   logic [8:0] w_cell_y;
   logic       w_unused_rnd_y9;

   function automatic logic [1:0] cell_dx(input logic [3:0] k);
      case (k)
         4'd1, 4'd4, 4'd7: cell_dx = 2'd1;
         4'd2, 4'd5, 4'd8: cell_dx = 2'd2;
         default:          cell_dx = 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] cell_dy(input logic [3:0] k);
      case (k)
         4'd3, 4'd4, 4'd5: cell_dy = 2'd1;
         4'd6, 4'd7, 4'd8: cell_dy = 2'd2;
         default:          cell_dy = 2'd0;
      endcase
   endfunction

   assign w_unused_rnd_y9 = i_rnd_y[9];

   // In CHECK r_k counts cycles (0..9): cycle k issues query k and samples query k-1.
   always_comb begin
      w_oob      = (i_rnd_x > XLim) || (i_rnd_y[8:0] > YLim);
      w_reject   = ((r_state == StLatch) && w_oob) ||
                   ((r_state == StCheck) && (r_k != 4'd0) && i_occ_hit);
      w_try_next = r_try_cnt + 8'd1;
      w_k_next   = r_k + 4'd1;
      w_cell_x   = r_cx + {8'd0, cell_dx(w_k_next)};
      w_cell_y   = r_cy + {7'd0, cell_dy(w_k_next)};
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_cx         <= '0;
         r_cy         <= '0;
         r_k          <= '0;
         r_try_cnt    <= '0;
         r_occ_x      <= '0;
         r_occ_y      <= '0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_pix_we     <= 1'b0;
         r_food_x     <= '0;
         r_food_y     <= '0;
         r_food_valid <= 1'b0;
         r_lfsr_step  <= 1'b0;
         r_write_done <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_lfsr_step  <= 1'b0;
         r_write_done <= 1'b0;
         r_fail       <= 1'b0;
         if (r_state == StLatch) begin
            r_cx <= i_rnd_x;
            r_cy <= i_rnd_y[8:0];
         end
         if (w_reject) begin
            r_try_cnt <= w_try_next;
            if (w_try_next == TryMax) begin
               r_fail  <= 1'b1;
               r_state <= StFail;
            end else begin
               r_lfsr_step <= 1'b1;
               r_state     <= StStep;
            end
         end else begin
            case (r_state)
               StIdle: begin
                  if (i_spawn_req) begin
                     r_food_valid <= 1'b0;
                     r_try_cnt    <= '0;
                     r_lfsr_step  <= 1'b1;
                     r_state      <= StStep;
                  end
               end
               StStep: r_state <= StLatch;
               StLatch: begin
                  r_k     <= '0;
                  r_occ_x <= i_rnd_x;
                  r_occ_y <= i_rnd_y[8:0];
                  r_state <= StCheck;
               end
               StCheck: begin
                  if (r_k == 4'd9) begin
                     r_k      <= '0;
                     r_pix_x  <= r_cx;
                     r_pix_y  <= r_cy;
                     r_pix_we <= 1'b1;
                     r_state  <= StDraw;
                  end else begin
                     r_k <= w_k_next;
                     if (r_k != 4'd8) begin
                        r_occ_x <= w_cell_x;
                        r_occ_y <= w_cell_y;
                     end
                  end
               end
               StDraw: begin
                  if (i_pix_ready) begin
                     if (r_k == 4'd8) begin
                        r_pix_we     <= 1'b0;
                        r_write_done <= 1'b1;
                        r_state      <= StDone;
                     end else begin
                        r_k     <= w_k_next;
                        r_pix_x <= w_cell_x;
                        r_pix_y <= w_cell_y;
                     end
                  end
               end
               StDone: begin
                  r_food_x     <= r_cx;
                  r_food_y     <= r_cy;
                  r_food_valid <= 1'b1;
                  r_state      <= StIdle;
               end
               StFail:  r_state <= StIdle;
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_lfsr_step  = r_lfsr_step;
   assign o_occ_x      = r_occ_x;
   assign o_occ_y      = r_occ_y;
   assign o_pix_x      = r_pix_x;
   assign o_pix_y      = r_pix_y;
   assign o_pix_we     = r_pix_we;
   assign o_food_x     = r_food_x;
   assign o_food_y     = r_food_y;
   assign o_food_valid = r_food_valid;
   assign o_write_done = r_write_done;
   assign o_busy       = (r_state != StIdle);
   assign o_fail       = r_fail;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl with a behavioural LFSR, occupancy memory and
// frame-buffer ready model; cycle 0 is the cycle in which spawn_req is high.
module tb_food_spawn_ctrl;

   logic       clk = 1'b0;
   logic       i_reset, i_spawn_req, i_occ_hit, i_pix_ready;
   logic [9:0] i_rnd_x, i_rnd_y;
   logic       o_lfsr_step, o_pix_we, o_food_valid, o_write_done, o_busy, o_fail;
   logic [9:0] o_occ_x, o_pix_x, o_food_x;
   logic [8:0] o_occ_y, o_pix_y, o_food_y;

   always #5 clk = ~clk;

   food_spawn_ctrl #(
      .X_MAX     (640),
      .Y_MAX     (480),
      .MAX_TRIES (3)
   ) u_dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_spawn_req  (i_spawn_req),
      .i_rnd_x      (i_rnd_x),
      .i_rnd_y      (i_rnd_y),
      .o_lfsr_step  (o_lfsr_step),
      .o_occ_x      (o_occ_x),
      .o_occ_y      (o_occ_y),
      .i_occ_hit    (i_occ_hit),
      .o_pix_x      (o_pix_x),
      .o_pix_y      (o_pix_y),
      .o_pix_we     (o_pix_we),
      .i_pix_ready  (i_pix_ready),
      .o_food_x     (o_food_x),
      .o_food_y     (o_food_y),
      .o_food_valid (o_food_valid),
      .o_write_done (o_write_done),
      .o_busy       (o_busy),
      .o_fail       (o_fail)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [9:0] tab_x [8];
   logic [9:0] tab_y [8];
   int         idx, cyc, n_steps, n_we, nwr, n_done, n_fail, done_cyc, fail_cyc;
   int         n_stall, stall_bad, stall_k, stall_left, n_watch;
   logic       fv_at_done, snake_en, echo;
   logic [9:0] snake_x, watch_x, stall_x;
   logic [8:0] snake_y, watch_y, stall_y;
   logic [9:0] wr_x [16];
   logic [8:0] wr_y [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      logic       step_now;
      logic [9:0] qx;
      logic [8:0] qy;
      if (echo) i_spawn_req = ((cyc >= 5) && (cyc <= 7)) || (cyc == 21);
      step_now = o_lfsr_step;
      qx = o_occ_x;
      qy = o_occ_y;
      if (o_lfsr_step) n_steps++;
      if (o_pix_we) n_we++;
      if (o_pix_we && i_pix_ready && nwr < 16) begin
         wr_x[nwr] = o_pix_x;
         wr_y[nwr] = o_pix_y;
         nwr++;
      end
      if (o_pix_we && !i_pix_ready) begin
         n_stall++;
         if (o_pix_x != stall_x || o_pix_y != stall_y) stall_bad++;
      end
      if (o_write_done) begin
         done_cyc   = cyc;
         fv_at_done = o_food_valid;
         n_done++;
      end
      if (o_fail) begin
         fail_cyc = cyc;
         n_fail++;
      end
      if (o_occ_x == watch_x && o_occ_y == watch_y) n_watch++;
      @(posedge clk);
      #1;
      cyc++;
      if (step_now) begin
         if (idx < 7) idx++;
         i_rnd_x = tab_x[idx];
         i_rnd_y = tab_y[idx];
      end
      i_occ_hit = snake_en && (qx == snake_x) && (qy == snake_y);
      if (stall_left > 0 && o_pix_we && nwr == stall_k) begin
         i_pix_ready = 1'b0;
         stall_left--;
      end else begin
         i_pix_ready = 1'b1;
      end
   endtask

   task automatic clear_counts();
      idx = -1; cyc = 0; n_steps = 0; n_we = 0; nwr = 0; n_done = 0; n_fail = 0;
      done_cyc = -1; fail_cyc = -1; n_stall = 0; stall_bad = 0; n_watch = 0;
      fv_at_done = 1'bx;
   endtask

   task automatic fill_tab(input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1);
      tab_x[0] = x0;
      tab_y[0] = y0;
      for (int i = 1; i < 8; i++) begin
         tab_x[i] = x1;
         tab_y[i] = y1;
      end
   endtask

   task automatic start_run();
      clear_counts();
      i_spawn_req = 1'b1;
      tick();
      i_spawn_req = 1'b0;
   endtask

   task automatic run(input int budget);
      for (int i = 0; i < budget && n_done == 0 && n_fail == 0; i++) tick();
   endtask

   task automatic check_writes(input string tag, input logic [9:0] ax, input logic [8:0] ay);
      for (int k = 0; k < 9; k++) begin
         check(tag, {wr_x[k], wr_y[k]}, {ax + 10'(k % 3), ay + 9'(k / 3)});
      end
   endtask

   initial begin
      i_reset = 1'b0; i_spawn_req = 1'b0; i_occ_hit = 1'b0; i_pix_ready = 1'b1;
      i_rnd_x = '0; i_rnd_y = '0; snake_en = 1'b0; echo = 1'b0;
      snake_x = '0; snake_y = '0; watch_x = 10'd1023; watch_y = 9'd511;
      stall_k = 0; stall_left = 0; stall_x = '0; stall_y = '0;
      clear_counts();
      #12;
      check("reset_outs", {o_lfsr_step, o_occ_x, o_occ_y, o_pix_x, o_pix_y, o_pix_we,
                           o_food_x, o_food_y, o_food_valid, o_write_done, o_busy, o_fail},
            64'd0);
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      tick();
      tick();

      // No obstruction
      fill_tab(10'd100, 10'd50, 10'd100, 10'd50);
      start_run();
      check("t1_step_c1", {o_lfsr_step, o_busy}, 2'b11);
      run(100);
      check("t1_done_seen", n_done, 1);
      check("t1_done_cyc", done_cyc, 22);
      check("t1_fv_at_done", fv_at_done, 1'b0);
      check("t1_nwr", nwr, 9);
      check_writes("t1_write", 10'd100, 9'd50);
      check("t1_steps", n_steps, 1);
      check("t1_food", {o_food_valid, o_food_x, o_food_y, o_busy, o_write_done},
            {1'b1, 10'd100, 9'd50, 1'b0, 1'b0});

      // Out of bounds first candidate; bit 9 of rnd_y must be ignored
      fill_tab(10'd638, 10'd10, 10'd200, 10'd522);
      watch_x = 10'd638; watch_y = 9'd10;
      start_run();
      run(100);
      check("t2_steps", n_steps, 2);
      check("t2_no_query_638", n_watch, 0);
      check("t2_done_cyc", done_cyc, 24);
      check("t2_first_wr", {wr_x[0], wr_y[0]}, {10'd200, 9'd10});
      check("t2_last_wr", {wr_x[8], wr_y[8]}, {10'd202, 9'd12});
      check("t2_food", {o_food_valid, o_food_x, o_food_y}, {1'b1, 10'd200, 9'd10});

      // Occupancy hit on cell k=4 of the first candidate
      fill_tab(10'd100, 10'd50, 10'd300, 10'd200);
      snake_en = 1'b1; snake_x = 10'd101; snake_y = 9'd51;
      watch_x = 10'd100; watch_y = 9'd52;
      start_run();
      run(100);
      check("t3_steps", n_steps, 2);
      check("t3_no_query_k6", n_watch, 0);
      check("t3_done_cyc", done_cyc, 30);
      check("t3_nwr", nwr, 9);
      check("t3_first_wr", {wr_x[0], wr_y[0]}, {10'd300, 9'd200});
      check("t3_food", {o_food_valid, o_food_x, o_food_y}, {1'b1, 10'd300, 9'd200});

      // Exhaustion: every candidate hits at k=0, MAX_TRIES=3
      fill_tab(10'd100, 10'd50, 10'd100, 10'd50);
      snake_x = 10'd100; snake_y = 9'd50;
      watch_x = 10'd1023; watch_y = 9'd511;
      start_run();
      run(100);
      check("t4_fail_seen", n_fail, 1);
      check("t4_fail_cyc", fail_cyc, 13);
      check("t4_steps", n_steps, 3);
      check("t4_no_we", n_we, 0);
      check("t4_no_done", n_done, 0);
      check("t4_food", {o_food_valid, o_food_x, o_food_y, o_fail},
            {1'b0, 10'd300, 9'd200, 1'b0});
      snake_en = 1'b0;

      // Backpressure: ready low for 5 cycles while k=2 is presented
      fill_tab(10'd100, 10'd50, 10'd100, 10'd50);
      stall_k = 2; stall_left = 5; stall_x = 10'd102; stall_y = 9'd50;
      start_run();
      run(100);
      check("t5_done_cyc", done_cyc, 27);
      check("t5_stall_cycles", n_stall, 5);
      check("t5_stall_stable", stall_bad, 0);
      check("t5_nwr", nwr, 9);
      check_writes("t5_write", 10'd100, 9'd50);
      check("t5_food", {o_food_valid, o_food_x, o_food_y}, {1'b1, 10'd100, 9'd50});

      // Reset while drawing cell k=5
      start_run();
      for (int i = 0; i < 40 && nwr < 5; i++) tick();
      check("t6_at_k5", {o_pix_we, o_pix_x, o_pix_y}, {1'b1, 10'd102, 9'd51});
      #2;
      i_reset = 1'b0;
      #1;
      check("t6_reset_outs", {o_lfsr_step, o_occ_x, o_occ_y, o_pix_x, o_pix_y, o_pix_we,
                              o_food_x, o_food_y, o_food_valid, o_write_done, o_busy, o_fail},
            64'd0);
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      clear_counts();
      for (int i = 0; i < 30; i++) tick();
      check("t6_no_we_after", n_we, 0);
      check("t6_no_step_after", n_steps + n_done, 0);
      check("t6_idle", {o_busy, o_food_valid}, 2'b00);

      // spawn_req while busy is ignored
      start_run();
      echo = 1'b1;
      run(100);
      for (int i = 0; i < 5; i++) tick();
      echo = 1'b0;
      check("t7_steps", n_steps, 1);
      check("t7_done_cyc", done_cyc, 22);
      check("t7_nwr", nwr, 9);
      check("t7_idle", {o_busy, o_food_valid}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
